// File: rtl/xpu_csma_pkg.sv
// Shared CSMA/CA definitions: state encodings, LFSR constants and the contention-window mask.
package xpu_csma_pkg;

    typedef enum logic [1:0] {
        CSMA_IDLE    = 2'd0,
        CSMA_DIFS    = 2'd1,
        CSMA_BACKOFF = 2'd2,
        CSMA_GRANT   = 2'd3
    } csma_state_e;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] cw_mask(input logic [3:0] cw_exp, input logic [3:0] exp_max);
        logic [3:0] e;
        e = (cw_exp > exp_max) ? exp_max : cw_exp;
        return (16'd1 << e) - 16'd1;
    endfunction

endpackage

// File: rtl/csma_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, seeded on reset; source of backoff randomness.
module csma_lfsr16
    import xpu_csma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    output logic [15:0] o_out
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb  = ^(r_lfsr & LFSR_TAPS);
    assign o_out = r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (i_en) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

endmodule

// File: rtl/csma_backoff.sv
// CSMA/CA access engine: DIFS idle wait, frozen slot backoff, grant held until tx_start.
// Build option CSMA_BACKOFF_LFSR_EN: backoff drawn from an internal LFSR instead of i_rand_in.
module csma_backoff
    import xpu_csma_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int BO_WIDTH   = 10,
    parameter int CW_EXP_MAX = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_ch_idle,
    input  logic                 i_tx_req,
    input  logic                 i_tx_start,
    input  logic [3:0]           i_cw_exp,
    input  logic [CNT_WIDTH-1:0] i_difs_cycles,
    input  logic [CNT_WIDTH-1:0] i_slot_cycles,
    input  logic [BO_WIDTH-1:0]  i_rand_in,
    output logic                 o_tx_grant,
    output logic [BO_WIDTH-1:0]  o_backoff_cnt,
    output logic [1:0]           o_state_out
);

    csma_state_e          r_state, w_state_nx;
    logic [CNT_WIDTH-1:0] r_difs_cnt, w_difs_nx;
    logic [CNT_WIDTH-1:0] r_slot_cnt, w_slot_nx;
    logic [BO_WIDTH-1:0]  r_backoff_cnt, w_backoff_nx;
    logic                 r_grant;

    logic [CNT_WIDTH-1:0] w_difs_len, w_slot_len;
    logic                 w_difs_last, w_slot_last;
    logic [15:0]          w_mask;
    logic [BO_WIDTH-1:0]  w_rand;
    logic [BO_WIDTH-1:0]  w_load;

`ifdef CSMA_BACKOFF_LFSR_EN
    logic [15:0] w_lfsr;

    csma_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (1'b1),
        .o_out (w_lfsr)
    );

    assign w_rand = w_lfsr[BO_WIDTH-1:0];
`else
    assign w_rand = i_rand_in;
`endif

    // A zero length would never match a count, so it behaves as one cycle
    assign w_difs_len  = (i_difs_cycles == '0) ? CNT_WIDTH'(1) : i_difs_cycles;
    assign w_slot_len  = (i_slot_cycles == '0) ? CNT_WIDTH'(1) : i_slot_cycles;
    assign w_difs_last = (r_difs_cnt == w_difs_len - CNT_WIDTH'(1));
    assign w_slot_last = (r_slot_cnt == w_slot_len - CNT_WIDTH'(1));
    assign w_mask      = cw_mask(i_cw_exp, 4'(CW_EXP_MAX));
    assign w_load      = w_rand & w_mask[BO_WIDTH-1:0];

    always_comb begin
        w_state_nx   = r_state;
        w_difs_nx    = r_difs_cnt;
        w_slot_nx    = r_slot_cnt;
        w_backoff_nx = r_backoff_cnt;
        case (r_state)
            CSMA_IDLE: begin
                if (i_tx_req) begin
                    w_backoff_nx = w_load;
                    w_difs_nx    = '0;
                    w_slot_nx    = '0;
                    w_state_nx   = CSMA_DIFS;
                end
            end
            CSMA_DIFS: begin
                if (!i_tx_req) begin
                    w_state_nx = CSMA_IDLE;
                end else if (i_ch_idle) begin
                    if (w_difs_last) begin
                        w_difs_nx  = '0;
                        w_slot_nx  = '0;
                        w_state_nx = (r_backoff_cnt == '0) ? CSMA_GRANT : CSMA_BACKOFF;
                    end else begin
                        w_difs_nx = r_difs_cnt + CNT_WIDTH'(1);
                    end
                end else begin
                    w_difs_nx = '0;
                end
            end
            CSMA_BACKOFF: begin
                if (!i_tx_req) begin
                    w_state_nx = CSMA_IDLE;
                end else if (i_ch_idle) begin
                    if (w_slot_last) begin
                        w_slot_nx    = '0;
                        w_backoff_nx = r_backoff_cnt - BO_WIDTH'(1);
                        if (r_backoff_cnt == BO_WIDTH'(1)) begin
                            w_state_nx = CSMA_GRANT;
                        end
                    end else begin
                        w_slot_nx = r_slot_cnt + CNT_WIDTH'(1);
                    end
                end else begin
                    // Busy beats slot end: counter frozen, partial slot discarded
                    w_slot_nx  = '0;
                    w_difs_nx  = '0;
                    w_state_nx = CSMA_DIFS;
                end
            end
            CSMA_GRANT: begin
                if (i_tx_start || !i_tx_req) begin
                    w_state_nx = CSMA_IDLE;
                end
            end
            default: w_state_nx = CSMA_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= CSMA_IDLE;
            r_difs_cnt    <= '0;
            r_slot_cnt    <= '0;
            r_backoff_cnt <= '0;
            r_grant       <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_difs_cnt    <= w_difs_nx;
            r_slot_cnt    <= w_slot_nx;
            r_backoff_cnt <= w_backoff_nx;
            r_grant       <= (w_state_nx == CSMA_GRANT);
        end
    end

    assign o_tx_grant    = r_grant;
    assign o_backoff_cnt = r_backoff_cnt;
    assign o_state_out   = r_state;

endmodule

// File: tb/tb_csma_backoff.sv
// Directed bench for csma_backoff: latency, backoff countdown, busy freeze, CW masking, abort, reset.
module tb_csma_backoff;

    logic        clk;
    logic        rst;
    logic        ch_idle;
    logic        tx_req;
    logic        tx_start;
    logic [3:0]  cw_exp;
    logic [15:0] difs_cycles;
    logic [15:0] slot_cycles;
    logic [9:0]  rand_in;
    logic        tx_grant;
    logic [9:0]  backoff_cnt;
    logic [1:0]  state_out;

    int n_cmp;
    int n_err;

    csma_backoff dut (
        .clk           (clk),
        .rst           (rst),
        .i_ch_idle     (ch_idle),
        .i_tx_req      (tx_req),
        .i_tx_start    (tx_start),
        .i_cw_exp      (cw_exp),
        .i_difs_cycles (difs_cycles),
        .i_slot_cycles (slot_cycles),
        .i_rand_in     (rand_in),
        .o_tx_grant    (tx_grant),
        .o_backoff_cnt (backoff_cnt),
        .o_state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges from the first tx_req edge until tx_grant is seen
    task automatic wait_grant(input int budget, output int edges);
        edges = 0;
        while (!tx_grant && edges < budget) begin
            tick();
            edges++;
        end
    endtask

    task automatic release_grant();
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_req   = 1'b0;
    endtask

    logic [9:0] run_a[$];
    logic [9:0] run_b[$];

    task automatic lfsr_run(output logic [9:0] vals[4]);
        rst    = 1'b1;
        tx_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_in = 10'($urandom_range(0, 1023));
            tx_req  = 1'b1;
            tick();
            vals[i] = backoff_cnt;
            tx_req  = 1'b0;
            tick();
        end
    endtask

    initial begin
        int n;
        int g;
        logic [9:0] va[4];
        logic [9:0] vb[4];
        n_cmp       = 0;
        n_err       = 0;
        rst         = 1'b1;
        ch_idle     = 1'b1;
        tx_req      = 1'b0;
        tx_start    = 1'b0;
        cw_exp      = 4'd4;
        difs_cycles = 16'd4;
        slot_cycles = 16'd9;
        rand_in     = 10'd0;
        tick();
        tick();
        check_eq("reset_state", 32'(state_out), 32'd0);
        check_eq("reset_grant", 32'(tx_grant), 32'd0);
        check_eq("reset_backoff", 32'(backoff_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("idle_after_reset", 32'(state_out), 32'd0);

`ifdef CSMA_BACKOFF_LFSR_EN
        cw_exp = 4'd10;
        lfsr_run(va);
        lfsr_run(vb);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("lfsr_repeat_%0d", i), 32'(vb[i]), 32'(va[i]));
        end
        check_eq("lfsr_nonzero", 32'((va[0] | va[1] | va[2] | va[3]) != 10'd0), 32'd1);
`else
        // 1: zero backoff, DIFS=4 -> grant on the 5th edge; tx_start in DIFS ignored
        tx_req   = 1'b1;
        tx_start = 1'b1;
        tick();
        tick();
        tx_start = 1'b0;
        wait_grant(50, n);
        check_eq("t1_latency", 32'(n + 2), 32'd5);
        check_eq("t1_state_grant", 32'(state_out), 32'd3);
        ch_idle = 1'b0;
        tick();
        tick();
        check_eq("t1_grant_ignores_busy", 32'(tx_grant), 32'd1);
        ch_idle = 1'b1;
        release_grant();
        check_eq("t1_grant_drop", 32'(tx_grant), 32'd0);
        check_eq("t1_idle", 32'(state_out), 32'd0);
        tick();

        // 2: backoff 3, slot 9 -> grant on edge 32
        rand_in = 10'd3;
        tx_req  = 1'b1;
        g = 0;
        for (int e = 1; e <= 60; e++) begin
            tick();
            if (e == 1)  check_eq("t2_load", 32'(backoff_cnt), 32'd3);
            if (e == 5)  check_eq("t2_enter_backoff", 32'(state_out), 32'd2);
            if (e == 14) check_eq("t2_bo_after_slot1", 32'(backoff_cnt), 32'd2);
            if (e == 23) check_eq("t2_bo_after_slot2", 32'(backoff_cnt), 32'd1);
            if (tx_grant && g == 0) g = e;
        end
        check_eq("t2_grant_edge", 32'(g), 32'd32);
        check_eq("t2_bo_zero", 32'(backoff_cnt), 32'd0);
        release_grant();
        tick();

        // 3: busy for edges 18..22, three cycles into slot 2 -> grant on edge 44
        tx_req = 1'b1;
        g = 0;
        for (int e = 1; e <= 70 && g == 0; e++) begin
            ch_idle = !(e >= 18 && e <= 22);
            tick();
            if (e == 18) check_eq("t3_busy_to_difs", 32'(state_out), 32'd1);
            if (e == 22) check_eq("t3_bo_frozen", 32'(backoff_cnt), 32'd2);
            if (e == 26) check_eq("t3_back_to_backoff", 32'(state_out), 32'd2);
            if (tx_grant) g = e;
        end
        check_eq("t3_grant_edge", 32'(g), 32'd44);
        ch_idle = 1'b1;
        // tx_start together with tx_req drop behaves as a normal release
        tx_req   = 1'b0;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check_eq("t3_release_state", 32'(state_out), 32'd0);
        check_eq("t3_release_grant", 32'(tx_grant), 32'd0);

        // 4: CW masking and saturation
        rand_in = 10'd1023;
        cw_exp  = 4'd2;
        tx_req  = 1'b1;
        tick();
        check_eq("t4_cw2", 32'(backoff_cnt), 32'd3);
        tx_req = 1'b0;
        tick();
        check_eq("t4_abort_keeps_bo", 32'(backoff_cnt), 32'd3);
        cw_exp = 4'd15;
        tx_req = 1'b1;
        tick();
        check_eq("t4_cw15_sat", 32'(backoff_cnt), 32'd1023);
        tx_req = 1'b0;
        tick();
        cw_exp = 4'd0;
        tx_req = 1'b1;
        tick();
        check_eq("t4_cw0", 32'(backoff_cnt), 32'd0);
        tx_req = 1'b0;
        tick();

        // 5a: abort inside backoff
        rand_in = 10'd5;
        cw_exp  = 4'd4;
        tx_req  = 1'b1;
        for (int e = 0; e < 8; e++) tick();
        check_eq("t5_in_backoff", 32'(state_out), 32'd2);
        tx_req = 1'b0;
        tick();
        check_eq("t5_abort_idle", 32'(state_out), 32'd0);
        check_eq("t5_abort_bo", 32'(backoff_cnt), 32'd5);
        g = 0;
        for (int e = 0; e < 5; e++) begin
            tick();
            if (tx_grant) g = 1;
        end
        check_eq("t5_no_grant", 32'(g), 32'd0);

        // Zero DIFS/slot lengths act as one cycle
        difs_cycles = 16'd0;
        rand_in     = 10'd0;
        tx_req      = 1'b1;
        wait_grant(50, n);
        check_eq("difs0_latency", 32'(n), 32'd2);
        release_grant();
        tick();
        difs_cycles = 16'd1;
        slot_cycles = 16'd0;
        rand_in     = 10'd2;
        tx_req      = 1'b1;
        wait_grant(50, n);
        check_eq("slot0_latency", 32'(n), 32'd4);
        release_grant();
        tick();
        difs_cycles = 16'd4;
        slot_cycles = 16'd9;
`endif

        // 5b: reset in the middle of DIFS discards everything
        rand_in = 10'd7;
        cw_exp  = 4'd4;
        tx_req  = 1'b1;
        tick();
        tick();
        check_eq("t5_mid_difs", 32'(state_out), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_state", 32'(state_out), 32'd0);
        check_eq("t5_rst_bo", 32'(backoff_cnt), 32'd0);
        check_eq("t5_rst_grant", 32'(tx_grant), 32'd0);
        tx_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check_eq("t5_after_rst", 32'(state_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
